// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO with private storage, registered read data, occupancy count,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_set;
  logic                  unf_set;

  // Status flags decode from the registered count only, so no input reaches an output.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A read in the same cycle frees the slot, so a write at full is still accepted.
  assign wr_acc  = wr_en && (!full || rd_en);
  assign rd_acc  = rd_en && !empty;
  assign ovf_set = wr_en && !wr_acc;
  assign unf_set = rd_en && empty;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + ONE_C;
      end
      if (rd_acc) begin
        rptr <= rptr + ONE_C;
        dout <= mem[rptr[ADDR_WIDTH-1:0]];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      // A fresh error wins over a simultaneous clear.
      overflow  <= ovf_set || (overflow  && !err_clr);
      underflow <= unf_set || (underflow && !err_clr);
    end
  end

endmodule

// File: doc/sync_fifo_ram.md
# sync_fifo_ram

Single-clock, parametrised FIFO with its own storage array, registered read data, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the single-clock successor to the team's dual-port RAM primitive and is the standard buffer between same-clock producer and consumer pipeline stages. Both sides use a plain enable handshake.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH words
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (legal 1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (legal 0..DEPTH-1)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data, sampled when wr_en accepted
- rd_en  in  1  read request
- dout  out  DATA_WIDTH  read data, registered
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  ADDR_WIDTH+1  words held, 0..DEPTH
- overflow  out  1  sticky: write attempted and rejected
- underflow  out  1  sticky: read attempted and rejected
- err_clr  in  1  synchronous clear of overflow/underflow

## Operation
- Storage: DEPTH x DATA_WIDTH array, not reset. Write and read pointers are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address the array, and the MSB is the wrap bit. Pointers wrap modulo 2*DEPTH.
- count is a register. It is +1 on an accepted write only, -1 on an accepted read only, and unchanged when both or neither are accepted. All four status flags decode combinationally from registered count.
- Write acceptance: wr_en && (!full || rd_en). A write is written to mem[wptr], and wptr increments.
- Read acceptance: rd_en && !empty. dout is loaded with mem[rptr], and rptr increments. Without an accepted read, dout holds its value.
- Full + wr_en + rd_en: both are accepted, count stays DEPTH, and overflow is not set.
- Empty + wr_en + rd_en: the write is accepted and the read is rejected. count becomes 1, underflow is set, and dout holds.
- Rejected write (wr_en, full, !rd_en): no state change except overflow <= 1.
- Rejected read (rd_en, empty): no state change except underflow <= 1.
- err_clr clears both sticky flags. A new error in the same cycle takes priority, so that flag stays 1.
- Reset (rst_n low, any time, including mid-transfer) applies immediately:
  - Pointers and count are 0.
  - dout = 0.
  - empty = 1, full = 0.
  - almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0.
  - Array contents are undefined afterwards and never observable.

## Timing
- Write-to-read latency: a word written at edge N is readable by rd_en sampled at edge N+1. empty deasserts after edge N.
- Read latency: one cycle. With rd_en accepted at edge N, dout is valid from edge N until the next accepted read.
- Flags and count change only after a clock edge or on asynchronous reset. There are no combinational paths from wr_en or rd_en to any output.
- Reset release is synchronous to the first clk edge with rst_n high. The first accepted operation can occur on that edge.
- Throughput: one write and one read per cycle, sustained indefinitely when neither full nor empty.

## Test plan
- Fill/drain, DATA_WIDTH=8, ADDR_WIDTH=4: write 0x00..0x0F, then read 16 times.
  - count = 16 and full = 1 after the 16th write.
  - almost_full first asserts at count 14.
  - dout returns 0x00..0x0F in order, one cycle after each rd_en.
  - empty = 1 and almost_empty = 1 at the end.
- Overflow/underflow:
  - A 17th write with rd_en=0 gives overflow = 1 and count stays 16.
  - On an empty FIFO, rd_en gives underflow = 1 and dout is unchanged.
  - err_clr then clears both flags.
  - err_clr together with a new rejected write leaves overflow = 1.
- Wrap-around: run 40 cycles with continuous simultaneous write/read at count 3, using an incrementing pattern.
  - Data order is preserved across the pointer wrap.
  - count stays 3 throughout, and no error flags are set.
- Simultaneous at boundaries:
  - At full, wr_en=rd_en=1: count stays 16, the oldest word is read out, the new word is stored, and overflow = 0.
  - At empty, wr_en=rd_en=1: count becomes 1, underflow = 1, and the next read returns the written word.
- Reset mid-operation: assert rst_n low between clock edges while count = 9 and a write is pending.
  - Outputs change immediately: count = 0, empty = 1, dout = 0.
  - After release, writing 0xA5 and reading returns 0xA5.
